// File: rtl/tensor_replay_buffer.sv
// ============================================================================
// Module   : tensor_replay_buffer
// Brief    : Captures one DEPTH-beat tensor, then replays it REPEAT times.
//            Optional macro TENSOR_REPLAY_LAST_EN adds last/final markers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tensor_replay_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int IN_NUM     = 4,
    parameter int DEPTH      = 4,
    parameter int REPEAT     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in_0 [IN_NUM],
    input  logic                  data_in_0_valid,
    output logic                  data_in_0_ready,
    output logic [DATA_WIDTH-1:0] data_out_0 [IN_NUM],
    output logic                  data_out_0_valid,
`ifdef TENSOR_REPLAY_LAST_EN
    output logic                  data_out_0_last,
    output logic                  data_out_0_final,
`endif
    input  logic                  data_out_0_ready
);

    localparam int c_PTR_W = (DEPTH  > 1) ? $clog2(DEPTH)  : 1;
    localparam int c_REP_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam logic [c_PTR_W-1:0] c_PTR_MAX = c_PTR_W'(DEPTH - 1);
    localparam logic [c_REP_W-1:0] c_REP_MAX = c_REP_W'(REPEAT - 1);

    localparam logic [0:0] c_FILL  = 1'b0;
    localparam logic [0:0] c_DRAIN = 1'b1;

    logic [0:0]            r_state;
    logic [c_PTR_W-1:0]    r_wptr;
    logic [c_PTR_W-1:0]    r_rptr;
    logic [c_REP_W-1:0]    r_rep;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH][IN_NUM];

    logic w_accept;
    logic w_out_hs;

    assign w_accept = r_in_ready && data_in_0_valid;
    assign w_out_hs = r_out_valid && data_out_0_ready;

    // Storage is deliberately not reset; only the pointers are.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < IN_NUM; i++) begin
                r_mem[r_wptr][i] <= data_in_0[i];
            end
        end
    end

    // Ready/valid are registered so no input reaches them combinationally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= c_FILL;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_rep       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_FILL: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        if (r_wptr == c_PTR_MAX) begin
                            r_wptr      <= '0;
                            r_rptr      <= '0;
                            r_rep       <= '0;
                            r_state     <= c_DRAIN;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_wptr <= r_wptr + 1'b1;
                        end
                    end
                end
                c_DRAIN: begin
                    if (w_out_hs) begin
                        if (r_rptr != c_PTR_MAX) begin
                            r_rptr <= r_rptr + 1'b1;
                        end else begin
                            r_rptr <= '0;
                            if (r_rep != c_REP_MAX) begin
                                r_rep <= r_rep + 1'b1;
                            end else begin
                                r_rep       <= '0;
                                r_state     <= c_FILL;
                                r_out_valid <= 1'b0;
                                r_in_ready  <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_state     <= c_FILL;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign data_in_0_ready  = r_in_ready;
    assign data_out_0_valid = r_out_valid;

    // Output is a register-only mux, forced to zero whenever nothing is offered.
    always_comb begin
        for (int i = 0; i < IN_NUM; i++) begin
            data_out_0[i] = r_out_valid ? r_mem[r_rptr][i] : '0;
        end
    end

`ifdef TENSOR_REPLAY_LAST_EN
    assign data_out_0_last  = r_out_valid && (r_rptr == c_PTR_MAX);
    assign data_out_0_final = r_out_valid && (r_rptr == c_PTR_MAX) && (r_rep == c_REP_MAX);
`endif

endmodule

`default_nettype wire

// File: tb/tb_tensor_replay_buffer.sv
// Testbench for tensor_replay_buffer: scoreboard-checked replay, backpressure,
// sparse fill, DEPTH=1/REPEAT=1 pass-through and mid-drain reset.
`default_nettype none

module tb_tensor_replay_buffer;

    typedef struct {
        logic [15:0] d0;
        logic [15:0] d1;
        logic        last;
        logic        fin;
    } exp_t;

    logic clk;
    logic rst;

    logic [15:0] a_din  [2];
    logic [15:0] a_dout [2];
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [15:0] b_din  [2];
    logic [15:0] b_dout [2];
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
`ifdef TENSOR_REPLAY_LAST_EN
    logic a_last, a_final, b_last, b_final;
`endif

    exp_t a_q[$];
    exp_t b_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   a_pops   = 0;
    int   b_pops   = 0;
    logic        a_prev_stall = 1'b0;
    logic [15:0] a_prev0, a_prev1;

    tensor_replay_buffer #(.DATA_WIDTH(16), .IN_NUM(2), .DEPTH(4), .REPEAT(3)) u_a (
        .clk(clk), .rst(rst),
        .data_in_0(a_din), .data_in_0_valid(a_in_valid), .data_in_0_ready(a_in_ready),
        .data_out_0(a_dout), .data_out_0_valid(a_out_valid),
`ifdef TENSOR_REPLAY_LAST_EN
        .data_out_0_last(a_last), .data_out_0_final(a_final),
`endif
        .data_out_0_ready(a_out_ready)
    );

    tensor_replay_buffer #(.DATA_WIDTH(16), .IN_NUM(2), .DEPTH(1), .REPEAT(1)) u_b (
        .clk(clk), .rst(rst),
        .data_in_0(b_din), .data_in_0_valid(b_in_valid), .data_in_0_ready(b_in_ready),
        .data_out_0(b_dout), .data_out_0_valid(b_out_valid),
`ifdef TENSOR_REPLAY_LAST_EN
        .data_out_0_last(b_last), .data_out_0_final(b_final),
`endif
        .data_out_0_ready(b_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected replay of a DEPTH=4/REPEAT=3 tensor whose beat k = {b0+k, b1+k}.
    task automatic push_a(input logic [15:0] b0, input logic [15:0] b1);
        exp_t e;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) begin
                e.d0   = b0 + 16'(k);
                e.d1   = b1 + 16'(k);
                e.last = (k == 3);
                e.fin  = (k == 3) && (r == 2);
                a_q.push_back(e);
            end
        end
    endtask

    task automatic push_b(input logic [15:0] v0, input logic [15:0] v1);
        exp_t e;
        e.d0 = v0; e.d1 = v1; e.last = 1'b1; e.fin = 1'b1;
        b_q.push_back(e);
    endtask

    // Returns at posedge+1 after the accepting edge; cyc counts cycles spent.
    task automatic wait_acc(input bit sel_b, output int cyc);
        logic r;
        cyc = 0;
        do begin
            @(negedge clk);
            r = sel_b ? b_in_ready : a_in_ready;
            @(posedge clk);
            #1;
            cyc++;
        end while (!r && cyc < 50);
        if (!r) begin
            failures++;
            $display("FAIL accept_timeout actual=0 required=1");
        end
    endtask

    task automatic fill_a(input logic [15:0] b0, input logic [15:0] b1, input bit sparse);
        int cyc;
        for (int k = 0; k < 4; k++) begin
            if (sparse && k > 0) begin
                a_in_valid = 1'b0;
                a_din[0] = 16'hDEAD;
                a_din[1] = 16'hBEEF;
                @(posedge clk);
                #1;
                chk("sparse_gap_no_valid", {31'd0, a_out_valid}, 32'd0);
            end
            a_in_valid = 1'b1;
            a_din[0] = b0 + 16'(k);
            a_din[1] = b1 + 16'(k);
            wait_acc(1'b0, cyc);
            if (k < 3) chk("no_early_valid", {31'd0, a_out_valid}, 32'd0);
            else       chk("first_valid_latency", {31'd0, a_out_valid}, 32'd1);
        end
        a_in_valid = 1'b0;
    endtask

    task automatic drain_a(input int n, input bit bp);
        int target;
        int c;
        target = a_pops + n;
        c = 0;
        while (a_pops < target && c < 300) begin
            a_out_ready = bp ? (c % 3 == 0) : 1'b1;
            @(posedge clk);
            #1;
            c++;
        end
        a_out_ready = 1'b1;
        chk("drain_beats", a_pops, target);
        chk("ready_after_drain", {31'd0, a_in_ready}, 32'd1);
        chk("valid_after_drain", {31'd0, a_out_valid}, 32'd0);
    endtask

    // Scoreboard monitor for DUT A: pops on every presented handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            a_prev_stall = 1'b0;
        end else begin
            if (a_prev_stall) begin
                chk("stall_hold_valid", {31'd0, a_out_valid}, 32'd1);
                chk("stall_hold_data", {a_dout[0], a_dout[1]}, {a_prev0, a_prev1});
            end
            if (a_out_valid) begin
                chk("no_fill_during_drain", {31'd0, a_in_ready}, 32'd0);
                if (a_out_ready) begin
                    if (a_q.size() == 0) begin
                        failures++;
                        $display("FAIL a_unexpected_beat actual=%0h required=none", {a_dout[0], a_dout[1]});
                    end else begin
                        e = a_q.pop_front();
                        chk("a_beat_data", {a_dout[0], a_dout[1]}, {e.d0, e.d1});
`ifdef TENSOR_REPLAY_LAST_EN
                        chk("a_last", {31'd0, a_last}, {31'd0, e.last});
                        chk("a_final", {31'd0, a_final}, {31'd0, e.fin});
`endif
                    end
                    a_pops++;
                end
                a_prev_stall = !a_out_ready;
                a_prev0 = a_dout[0];
                a_prev1 = a_dout[1];
            end else begin
                a_prev_stall = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst && b_out_valid && b_out_ready) begin
            if (b_q.size() == 0) begin
                failures++;
                $display("FAIL b_unexpected_beat actual=%0h required=none", {b_dout[0], b_dout[1]});
            end else begin
                e = b_q.pop_front();
                chk("b_beat_data", {b_dout[0], b_dout[1]}, {e.d0, e.d1});
`ifdef TENSOR_REPLAY_LAST_EN
                chk("b_last", {31'd0, b_last}, {31'd0, e.last});
                chk("b_final", {31'd0, b_final}, {31'd0, e.fin});
`endif
            end
            b_pops++;
        end
    end

    initial begin
        int cyc;
        int c;
        rst = 1'b0;
        a_in_valid = 1'b0; a_out_ready = 1'b1; a_din[0] = '0; a_din[1] = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b1; b_din[0] = '0; b_din[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_a_ready", {31'd0, a_in_ready}, 32'd0);
        chk("reset_a_valid", {31'd0, a_out_valid}, 32'd0);
        chk("reset_a_data", {a_dout[0], a_dout[1]}, 32'd0);
        chk("reset_b_valid", {31'd0, b_out_valid}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_a_ready", {31'd0, a_in_ready}, 32'd1);

        // Plain replay order.
        push_a(16'h0000, 16'h0010);
        fill_a(16'h0000, 16'h0010, 1'b0);
        drain_a(12, 1'b0);

        // Downstream backpressure 1,0,0 pattern.
        push_a(16'h0040, 16'h0050);
        fill_a(16'h0040, 16'h0050, 1'b0);
        drain_a(12, 1'b1);

        // Sparse upstream valid.
        push_a(16'h0060, 16'h0070);
        fill_a(16'h0060, 16'h0070, 1'b1);
        drain_a(12, 1'b0);

        // DEPTH=1/REPEAT=1 single beat.
        push_b(16'hABCD, 16'h1234);
        b_in_valid = 1'b1; b_din[0] = 16'hABCD; b_din[1] = 16'h1234;
        wait_acc(1'b1, cyc);
        b_in_valid = 1'b0;
        chk("b_valid_next_cycle", {31'd0, b_out_valid}, 32'd1);
        @(posedge clk);
        #1;
        chk("b_ready_returns", {31'd0, b_in_ready}, 32'd1);
        chk("b_single_pops", b_pops, 32'd1);

        // Back-to-back tensors A,B with valid held high.
        push_b(16'hAAAA, 16'hA5A5);
        push_b(16'hBBBB, 16'hB5B5);
        b_in_valid = 1'b1; b_din[0] = 16'hAAAA; b_din[1] = 16'hA5A5;
        wait_acc(1'b1, cyc);
        b_din[0] = 16'hBBBB; b_din[1] = 16'hB5B5;
        chk("b_ready_low_holding_a", {31'd0, b_in_ready}, 32'd0);
        wait_acc(1'b1, cyc);
        b_in_valid = 1'b0;
        chk("b_ready_low_cycles", cyc, 32'd2);
        @(posedge clk);
        #1;
        chk("b_b2b_pops", b_pops, 32'd3);

        // Reset after 5 of 12 replay beats.
        push_a(16'h0030, 16'h0040);
        fill_a(16'h0030, 16'h0040, 1'b0);
        c = a_pops + 5;
        cyc = 0;
        while (a_pops < c && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("pre_reset_pops", a_pops, c);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset_valid", {31'd0, a_out_valid}, 32'd0);
        chk("midreset_ready", {31'd0, a_in_ready}, 32'd0);
        chk("midreset_data", {a_dout[0], a_dout[1]}, 32'd0);
        a_q.delete();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("after_reset_ready", {31'd0, a_in_ready}, 32'd1);
        chk("after_reset_valid", {31'd0, a_out_valid}, 32'd0);
        push_a(16'h0010, 16'h0020);
        fill_a(16'h0010, 16'h0020, 1'b0);
        drain_a(12, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk("a_queue_empty", a_q.size(), 32'd0);
        chk("b_queue_empty", b_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
